// File: rtl/morse_tx_scheduler.sv
// Morse transmit sequencer: queues letter indices, keys each 11-bit code MSB-first
// on a divided unit tick, then holds the line low for an inter-letter gap.
module morse_tx_scheduler #(
    parameter int TICK_DIV   = 25000000,
    parameter int FIFO_DEPTH = 4,
    parameter int GAP_UNITS  = 3
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic       in_valid,
    input  logic [2:0] in_letter,
    output logic       in_ready,
    input  logic       abort,
    output logic       morse_out,
    output logic       busy,
    output logic       letter_done,
    output logic [2:0] queue_count
);
    localparam int TW = $clog2(TICK_DIV);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam logic [TW-1:0] TICK_RELOAD    = TW'(TICK_DIV - 1);
    localparam logic [2:0]    DEPTH_C        = 3'(FIFO_DEPTH);
    localparam logic [3:0]    LAST_CODE_UNIT = 4'd10;
    localparam logic [3:0]    LAST_GAP_UNIT  = 4'(GAP_UNITS - 1);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SEND, S_GAP} state_t;

    state_t          state_reg;
    logic [10:0]     shift_reg;
    logic [TW-1:0]   tick_reg;
    logic [3:0]      unit_reg;
    logic [PW-1:0]   wr_ptr_reg;
    logic [PW-1:0]   rd_ptr_reg;
    logic [2:0]      count_reg;
    logic            busy_reg;
    logic            done_reg;

    logic            push;
    logic            pop;
    logic            tick;
    logic [2:0]      head_letter;
    logic [2:0]      slot_q [FIFO_DEPTH];

    function automatic logic [10:0] letter_code(input logic [2:0] idx);
        logic [10:0] c;
        c = '0;
        case (idx)
            3'd0: c = 11'b10111000000;
            3'd1: c = 11'b11101010100;
            3'd2: c = 11'b11101011101;
            3'd3: c = 11'b11101010000;
            3'd4: c = 11'b10000000000;
            3'd5: c = 11'b10101110100;
            3'd6: c = 11'b11101110100;
            3'd7: c = 11'b10101010000;
        endcase
        return c;
    endfunction

    assign in_ready    = (count_reg < DEPTH_C) && !abort;
    assign push        = in_valid && in_ready;
    assign pop         = (state_reg == S_LOAD);
    assign tick        = (tick_reg == '0);
    assign head_letter = slot_q[rd_ptr_reg];

    // The shift register empties itself after 11 zero-fill shifts, so its MSB
    // is already low during GAP and IDLE and can drive the key line directly.
    assign morse_out   = shift_reg[10];
    assign busy        = busy_reg;
    assign letter_done = done_reg;
    assign queue_count = count_reg;

    for (genvar gi = 0; gi < FIFO_DEPTH; gi++) begin : g_slot
        logic [2:0] slot_reg;
        always_ff @(posedge clock or negedge resetn) begin
            if (!resetn) begin
                slot_reg <= '0;
            end else if (push && wr_ptr_reg == PW'(gi)) begin
                slot_reg <= in_letter;
            end
        end
        assign slot_q[gi] = slot_reg;
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_reg  <= S_IDLE;
            shift_reg  <= '0;
            tick_reg   <= '0;
            unit_reg   <= '0;
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            busy_reg   <= 1'b0;
            done_reg   <= 1'b0;
        end else if (abort) begin
            state_reg  <= S_IDLE;
            shift_reg  <= '0;
            tick_reg   <= '0;
            unit_reg   <= '0;
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            busy_reg   <= 1'b0;
            done_reg   <= 1'b0;
        end else begin
            done_reg <= 1'b0;

            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + PW'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PW'(1);
            end
            if (push && !pop) begin
                count_reg <= count_reg + 3'd1;
            end else if (!push && pop) begin
                count_reg <= count_reg - 3'd1;
            end

            case (state_reg)
                S_IDLE: begin
                    // A push arriving this cycle already counts, giving LOAD at +1.
                    if (count_reg != '0 || push) begin
                        state_reg <= S_LOAD;
                        busy_reg  <= 1'b1;
                    end
                end
                S_LOAD: begin
                    shift_reg <= letter_code(head_letter);
                    unit_reg  <= '0;
                    tick_reg  <= TICK_RELOAD;
                    state_reg <= S_SEND;
                end
                S_SEND: begin
                    if (tick) begin
                        tick_reg  <= TICK_RELOAD;
                        shift_reg <= {shift_reg[9:0], 1'b0};
                        if (unit_reg == LAST_CODE_UNIT) begin
                            unit_reg  <= '0;
                            state_reg <= S_GAP;
                        end else begin
                            unit_reg <= unit_reg + 4'd1;
                        end
                    end else begin
                        tick_reg <= tick_reg - TW'(1);
                    end
                    // Raised one cycle early so the registered pulse coincides
                    // with the cycle of the eleventh tick.
                    done_reg <= (tick_reg == TW'(1)) && (unit_reg == LAST_CODE_UNIT);
                end
                S_GAP: begin
                    if (tick) begin
                        tick_reg <= TICK_RELOAD;
                        if (unit_reg == LAST_GAP_UNIT) begin
                            unit_reg <= '0;
                            if (count_reg != '0) begin
                                state_reg <= S_LOAD;
                            end else begin
                                state_reg <= S_IDLE;
                                busy_reg  <= 1'b0;
                            end
                        end else begin
                            unit_reg <= unit_reg + 4'd1;
                        end
                    end else begin
                        tick_reg <= tick_reg - TW'(1);
                    end
                end
                default: state_reg <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_morse_tx_scheduler.sv
// Bench for morse_tx_scheduler: letter-table vectors, timing corner sequences and
// randomized traffic checked every cycle against a letter-phase reference model.
module tb_morse_tx_scheduler;
    localparam int TD         = 4;
    localparam int FD         = 4;
    localparam int GU         = 3;
    localparam int SEND_CYC   = 11 * TD;
    localparam int LETTER_END = SEND_CYC + GU * TD;
    localparam int MAXC       = 8192;

    logic       clock     = 1'b0;
    logic       resetn    = 1'b1;
    logic       in_valid  = 1'b0;
    logic [2:0] in_letter = 3'd0;
    logic       abort     = 1'b0;
    logic       in_ready;
    logic       morse_out;
    logic       busy;
    logic       letter_done;
    logic [2:0] queue_count;

    morse_tx_scheduler #(
        .TICK_DIV   (TD),
        .FIFO_DEPTH (FD),
        .GAP_UNITS  (GU)
    ) dut (
        .clock       (clock),
        .resetn      (resetn),
        .in_valid    (in_valid),
        .in_letter   (in_letter),
        .in_ready    (in_ready),
        .abort       (abort),
        .morse_out   (morse_out),
        .busy        (busy),
        .letter_done (letter_done),
        .queue_count (queue_count)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [2:0]  letter;
        logic [10:0] code;
        logic [7:0]  done_lat;
    } vec_t;
    vec_t vecs [8];

    int checks = 0;
    int passes = 0;
    int cyc    = 0;
    int base   = 0;

    logic       o_ready, o_morse, o_busy, o_done;
    logic [2:0] o_cnt;
    logic       rec_m [MAXC];
    logic       rec_b [MAXC];
    int         done_q [$];
    logic [2:0] exp_q [$];

    // Reference model: queue of letters plus the cycle offset within the current letter.
    logic [2:0] mq [$];
    bit         m_active = 1'b0;
    int         m_t      = 0;
    logic [2:0] m_letter = 3'd0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act === exp_v) passes++;
        else $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp_v);
    endtask

    task automatic model_reset();
        mq.delete();
        m_active = 1'b0;
        m_t      = 0;
    endtask

    function automatic logic [6:0] model_expect(input logic ab);
        logic e_ready, e_morse, e_busy, e_done;
        e_ready = (mq.size() < FD) && !ab;
        e_morse = 1'b0;
        if (m_active && m_t >= 1 && m_t <= SEND_CYC)
            e_morse = vecs[m_letter].code[10 - (m_t - 1) / TD];
        e_busy  = m_active;
        e_done  = m_active && (m_t == SEND_CYC);
        return {e_ready, e_morse, e_busy, e_done, 3'(mq.size())};
    endfunction

    task automatic model_update(input logic v, input logic [2:0] l, input logic ab);
        bit accept;
        if (ab) begin
            model_reset();
            return;
        end
        accept = v && (mq.size() < FD);
        if (!m_active) begin
            if (mq.size() > 0 || accept) begin
                m_active = 1'b1;
                m_t      = 0;
            end
        end else if (m_t == 0) begin
            m_letter = mq.pop_front();
            m_t      = 1;
        end else if (m_t == LETTER_END) begin
            if (mq.size() > 0) m_t = 0;
            else m_active = 1'b0;
        end else begin
            m_t++;
        end
        if (accept) mq.push_back(l);
    endtask

    task automatic step(input logic v, input logic [2:0] l, input logic ab);
        logic [6:0] exp_v;
        in_valid  = v;
        in_letter = l;
        abort     = ab;
        @(negedge clock);
        exp_v   = model_expect(ab);
        o_ready = in_ready;
        o_morse = morse_out;
        o_busy  = busy;
        o_done  = letter_done;
        o_cnt   = queue_count;
        check("cycle_outputs", {o_ready, o_morse, o_busy, o_done, o_cnt}, exp_v);
        if (cyc < MAXC) begin
            rec_m[cyc] = o_morse;
            rec_b[cyc] = o_busy;
        end
        if (o_done) done_q.push_back(cyc);
        if (exp_v[3]) $display("cycle %0d: letter %c sent", cyc, 8'd65 + 8'(m_letter));
        @(posedge clock);
        #1;
        model_update(v, l, ab);
        cyc++;
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 3'd0, 1'b0);
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        step(1'b0, 3'd0, 1'b0);
        while ((o_busy || o_cnt != 3'd0) && n < budget) begin
            step(1'b0, 3'd0, 1'b0);
            n++;
        end
        check("wait_idle_timeout", {31'd0, (o_busy || o_cnt != 3'd0)}, 32'd0);
    endtask

    // Decode the keyed bits behind each recorded letter_done and compare with exp_q.
    task automatic check_sent();
        logic [10:0] got;
        check("sent_count", done_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < done_q.size(); i++) begin
            for (int k = 0; k < 11; k++)
                got[10 - k] = rec_m[done_q[i] - (SEND_CYC - 1) + TD * k];
            check("sent_code", {21'd0, got}, {21'd0, vecs[exp_q[i]].code});
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{3'd0, 11'b10111000000, 8'd45};
        vecs[1] = '{3'd1, 11'b11101010100, 8'd45};
        vecs[2] = '{3'd2, 11'b11101011101, 8'd45};
        vecs[3] = '{3'd3, 11'b11101010000, 8'd45};
        vecs[4] = '{3'd4, 11'b10000000000, 8'd45};
        vecs[5] = '{3'd5, 11'b10101110100, 8'd45};
        vecs[6] = '{3'd6, 11'b11101110100, 8'd45};
        vecs[7] = '{3'd7, 11'b10101010000, 8'd45};

        #1 resetn = 1'b0;
        #1;
        check("reset_outputs", {in_ready, morse_out, busy, letter_done, queue_count}, 7'b1000000);
        #19 resetn = 1'b1;
        @(posedge clock);
        #1;

        // Single letter A: exact cycle timing from the push.
        done_q.delete();
        base = cyc;
        step(1'b1, 3'd0, 1'b0);
        idle(60);
        check("A_load", {rec_b[base + 1], rec_m[base + 1]}, 2'b10);
        for (int k = 0; k < 11; k++)
            check("A_bit", {rec_m[base + 2 + 4 * k], rec_m[base + 3 + 4 * k],
                            rec_m[base + 4 + 4 * k], rec_m[base + 5 + 4 * k]},
                  {4{vecs[0].code[10 - k]}});
        check("A_done_count", done_q.size(), 1);
        check("A_done_cycle", (done_q.size() > 0) ? done_q[0] - base : -1, 45);
        check("A_gap_end_busy", rec_b[base + 57], 1);
        check("A_idle_busy", rec_b[base + 58], 0);

        // Back-to-back E then H.
        done_q.delete();
        exp_q = '{3'd4, 3'd7};
        step(1'b1, 3'd4, 1'b0);
        step(1'b1, 3'd7, 1'b0);
        wait_idle(300);
        check_sent();
        if (done_q.size() >= 2) begin
            check("EH_spacing", done_q[1] - done_q[0], 57);
            check("EH_load_slot", {rec_b[done_q[0] + 13], rec_m[done_q[0] + 12],
                                   rec_m[done_q[0] + 13], rec_m[done_q[0] + 14]}, 4'b1001);
        end

        // FIFO full while the first letter is sending.
        done_q.delete();
        exp_q = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5};
        step(1'b1, 3'd1, 1'b0);
        idle(2);
        step(1'b1, 3'd2, 1'b0);
        step(1'b1, 3'd3, 1'b0);
        step(1'b1, 3'd4, 1'b0);
        step(1'b1, 3'd5, 1'b0);
        step(1'b1, 3'd6, 1'b0);
        check("full_ready_count", {o_ready, o_cnt}, 4'b0100);
        step(1'b0, 3'd0, 1'b0);
        check("full_hold", o_cnt, 4);
        wait_idle(600);
        check_sent();

        // Push during a LOAD cycle with two queued.
        done_q.delete();
        base = cyc;
        step(1'b1, 3'd0, 1'b0);
        step(1'b0, 3'd0, 1'b0);
        step(1'b1, 3'd1, 1'b0);
        step(1'b1, 3'd2, 1'b0);
        while (cyc < base + 58) step(1'b0, 3'd0, 1'b0);
        step(1'b1, 3'd3, 1'b0);
        check("pp_count_before", {o_busy, o_morse, o_cnt}, 5'b10010);
        step(1'b0, 3'd0, 1'b0);
        check("pp_count_after", o_cnt, 2);
        wait_idle(400);
        exp_q = '{3'd0, 3'd1, 3'd2, 3'd3};
        check_sent();

        // Abort mid-SEND of C with two queued, then a normal letter.
        done_q.delete();
        base = cyc;
        step(1'b1, 3'd2, 1'b0);
        step(1'b0, 3'd0, 1'b0);
        step(1'b1, 3'd0, 1'b0);
        step(1'b1, 3'd1, 1'b0);
        while (cyc < base + 20) step(1'b0, 3'd0, 1'b0);
        step(1'b1, 3'd3, 1'b1);
        check("abort_ready", {o_ready, o_busy, o_cnt}, 5'b01010);
        step(1'b0, 3'd0, 1'b0);
        check("abort_flush", {o_busy, o_morse, o_done, o_cnt}, 6'd0);
        idle(60);
        check("abort_no_done", done_q.size(), 0);
        exp_q = '{3'd4};
        step(1'b1, 3'd4, 1'b0);
        wait_idle(200);
        check_sent();

        // Letter table vectors.
        for (int i = 0; i < 8; i++) begin
            done_q.delete();
            exp_q.delete();
            exp_q.push_back(vecs[i].letter);
            base = cyc;
            step(1'b1, vecs[i].letter, 1'b0);
            wait_idle(200);
            check_sent();
            check("table_latency", (done_q.size() > 0) ? done_q[0] - base : -1,
                  {24'd0, vecs[i].done_lat});
        end

        // Asynchronous reset in the middle of a letter with one queued.
        step(1'b1, 3'd1, 1'b0);
        step(1'b0, 3'd0, 1'b0);
        step(1'b1, 3'd3, 1'b0);
        idle(10);
        #2 resetn = 1'b0;
        #1;
        check("reset_async", {in_ready, morse_out, busy, letter_done, queue_count}, 7'b1000000);
        model_reset();
        @(posedge clock);
        @(negedge clock);
        resetn = 1'b1;
        @(posedge clock);
        #1;
        step(1'b0, 3'd0, 1'b0);
        check("reset_release", {o_ready, o_busy, o_cnt}, 5'b10000);

        // Randomized traffic against the model.
        for (int n = 0; n < 1500; n++) begin
            logic       rv;
            logic [2:0] rl;
            logic       ra;
            rv = ($urandom_range(0, 3) == 0);
            rl = 3'($urandom_range(0, 7));
            ra = ($urandom_range(0, 299) == 0);
            step(rv, rl, ra);
        end
        wait_idle(800);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
